// File: rtl/md_if.sv
// Multiply/divide unit request bus: EX-stage start/op/operands in, busy and HI/LO out.
interface md_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, A, B, input busy, hi, lo);
   modport slave  (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS-style multiply/divide unit holding HI/LO.
// Build option: MDU_MADD_EN enables madd/maddu (op 6/7); otherwise they are no-ops.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo complete here in one edge
// S_MUL  | multiply (or madd) in flight, result latched, counting down
// S_DIV  | divide in flight, result latched, counting down
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   md_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [63:0] res_q, res_d;
   logic        wr_q, wr_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe, bm_safe;
   logic [31:0] qu, ru, qm, rm, qs, rs;
`ifdef MDU_MADD_EN
   logic [63:0] hilo;
`endif

   always_comb begin
      prod_s  = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
      prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
      a_neg   = bus.A[31];
      b_neg   = bus.B[31];
      a_mag   = a_neg ? -bus.A : bus.A;
      b_mag   = b_neg ? -bus.B : bus.B;
      // Divide-by-zero is never committed, so any non-zero divisor keeps the dividers defined.
      b_safe  = (bus.B == 32'd0) ? 32'd1 : bus.B;
      bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      qu      = bus.A / b_safe;
      ru      = bus.A % b_safe;
      // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 with no overflow case.
      qm      = a_mag / bm_safe;
      rm      = a_mag % bm_safe;
      qs      = (a_neg ^ b_neg) ? -qm : qm;
      rs      = a_neg ? -rm : rm;
`ifdef MDU_MADD_EN
      hilo    = {hi_q, lo_q};
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      wr_d    = wr_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  3'd0, 3'd1: begin
                     res_d   = (bus.op == 3'd0) ? prod_s : prod_u;
                     wr_d    = 1'b1;
                     cnt_d   = 16'(MULT_CYCLES);
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                  end
                  3'd2, 3'd3: begin
                     res_d   = (bus.op == 3'd2) ? {rs, qs} : {ru, qu};
                     wr_d    = (bus.B != 32'd0);
                     cnt_d   = 16'(DIV_CYCLES);
                     state_d = S_DIV;
                     busy_d  = 1'b1;
                  end
                  3'd4: hi_d = bus.A;
                  3'd5: lo_d = bus.A;
`ifdef MDU_MADD_EN
                  3'd6, 3'd7: begin
                     res_d   = hilo + ((bus.op == 3'd6) ? prod_s : prod_u);
                     wr_d    = 1'b1;
                     cnt_d   = 16'(MULT_CYCLES);
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                  end
`else
                  3'd6, 3'd7: ;
`endif
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               if (wr_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         res_q   <= 64'd0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
